dram_arbiter: RTL and testbench

//   Round-robin arbiter and burst sequencer for the shared byte-wide DRAM model (simple_memory).

---
 rtl/dram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Round-robin arbiter and burst sequencer for a single-port, byte-wide DRAM
//   model shared by instruction fetch (port 0) and the load/store units.
//   A requester posts a whole burst (base, length, direction) and holds it.
//   The arbiter owns the memory port for the length of the burst. It issues
//   one byte address per cycle and returns read data with per-port strobes.
//   It signals completion with a one-cycle done pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | arbitrate among requesters (the port pulsing done is masked)
//   BURST | one memory beat per cycle for the owning port
//   DRAIN | no memory access; last read data returns; done follows
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i/we_i      per-port level request / write direction
//   addr_i/len_i    per-port packed base address / burst length (bytes)
//   wdata_i         per-port packed write byte for the current beat
//   gnt_o           one-hot owner, BURST through DRAIN
//   wready_o        write byte consumed this cycle
//   rvalid_o/rdata_o per-port read strobe / shared read byte
//   beat_o          byte index of the beat issued this cycle
//   done_o          one-cycle completion pulse
//   busy_o          arbiter not idle
//   mem_*           memory port (read data has one cycle of latency)

module dram_arbiter #(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]  len_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   output logic [NUM_PORTS-1:0]            wready_o,
   output logic [NUM_PORTS-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic [LEN_WIDTH-1:0]            beat_o,
   output logic [NUM_PORTS-1:0]            done_o,
   output logic                            busy_o,
   output logic [ADDR_WIDTH-1:0]           mem_addr_o,
   output logic                            mem_we_o,
   output logic [DATA_WIDTH-1:0]           mem_din_o,
   input  logic [DATA_WIDTH-1:0]           mem_dout_i
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           owner_q, owner_d;
   logic                    we_q, we_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    beat_q, beat_d;
   logic [PW-1:0]           rr_q, rr_d;
   logic [NUM_PORTS-1:0]    done_q, done_d;
   logic [NUM_PORTS-1:0]    rvalid_q, rvalid_d;

   logic [NUM_PORTS-1:0]    elig;
   logic                    win_found;
   logic [PW-1:0]           win_idx;
   logic [PW-1:0]           win_next;
   logic [LEN_WIDTH-1:0]    win_len;

   // Rotating priority search starting at the rr pointer. The port pulsing
   // done is masked so its registered req deassert cannot win again.
   always_comb begin
      int idx;
      int nxt;
      elig      = req_i & ~done_q;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
      nxt = int'(win_idx) + 1;
      if (nxt >= NUM_PORTS) nxt = 0;
      win_next = PW'(nxt);
      win_len  = len_i[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      len_d    = len_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      rr_d     = rr_q;
      done_d   = '0;
      rvalid_d = '0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               owner_d = win_idx;
               we_d    = we_i[win_idx];
               addr_d  = addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               len_d   = win_len;
               beat_d  = '0;
               rr_d    = win_next;
               state_d = (win_len == '0) ? DRAIN : BURST;
            end
         end
         BURST: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            beat_d = beat_q + LEN_WIDTH'(1);
            if (!we_q) rvalid_d[owner_q] = 1'b1;
            if (beat_q == len_q - LEN_WIDTH'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            state_d         = IDLE;
            done_d[owner_q] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         we_q     <= 1'b0;
         len_q    <= '0;
         addr_q   <= '0;
         beat_q   <= '0;
         rr_q     <= '0;
         done_q   <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         rr_q     <= rr_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
      end
   end

   always_comb begin
      busy_o     = (state_q != IDLE);
      gnt_o      = '0;
      wready_o   = '0;
      mem_addr_o = '0;
      mem_we_o   = 1'b0;
      mem_din_o  = '0;
      beat_o     = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         gnt_o[p] = busy_o && (owner_q == PW'(p));
      end
      if (state_q == BURST) begin
         mem_addr_o = addr_q;
         mem_we_o   = we_q;
         beat_o     = beat_q;
         if (we_q) begin
            mem_din_o         = wdata_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            wready_o[owner_q] = 1'b1;
         end
      end
      // Read bus is held at zero outside read-return cycles so the whole
      // output set is quiet in reset and idle.
      rdata_o = (|rvalid_q) ? mem_dout_i : '0;
   end

   assign rvalid_o = rvalid_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
   localparam int NP = 3;
   localparam int AW = 24;
   localparam int DW = 8;
   localparam int LW = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP-1:0]     req, we;
   logic [NP*AW-1:0]  addr;
   logic [NP*LW-1:0]  len;
   logic [NP*DW-1:0]  wdata;
   logic [NP-1:0]     gnt, wready, rvalid, done;
   logic [DW-1:0]     rdata;
   logic [LW-1:0]     beat;
   logic              busy;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout;

   dram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .len_i(len),
      .wdata_i(wdata), .gnt_o(gnt), .wready_o(wready), .rvalid_o(rvalid), .rdata_o(rdata),
      .beat_o(beat), .done_o(done), .busy_o(busy), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_din_o(mem_din), .mem_dout_i(mem_dout)
   );

   always #5 clk = ~clk;

   // 256-byte memory model indexed by the low address byte, 1-cycle read latency
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_din;
      mem_dout <= mem[mem_addr[7:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int              port;
      bit              wr;
      logic [23:0]     base;
      int              len;
      logic [3:0][7:0] d;
   } vec_t;

   function automatic vec_t mk(input int port, input bit wr, input logic [23:0] base,
                               input int len, input logic [31:0] d);
      vec_t v;
      v.port = port; v.wr = wr; v.base = base; v.len = len; v.d = d;
      return v;
   endfunction

   task automatic all_quiet(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_din"}, mem_din, 0);
      chk({tag, "_beat"}, beat, 0);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wready"}, wready, 0);
   endtask

   // One burst from a single requester, checked cycle by cycle T1..T_len+2
   task automatic run_vec(input vec_t v);
      int p;
      logic [23:0] ea;
      p = v.port;
      @(posedge clk); #2;
      we[p] = v.wr;
      addr[p*AW +: AW] = v.base;
      len[p*LW +: LW] = LW'(v.len);
      req[p] = 1'b1;
      chk("t0_busy", busy, 0);
      for (int k = 1; k <= v.len + 2; k++) begin
         @(posedge clk); #1;
         if (v.wr && k <= v.len) wdata[p*DW +: DW] = v.d[beat[1:0]];
         #1;
         if (k <= v.len) begin
            ea = v.base + 24'(k - 1);
            chk("beat_gnt", gnt, 32'(1) << p);
            chk("beat_addr", mem_addr, ea);
            chk("beat_idx", beat, k - 1);
            chk("beat_we", mem_we, v.wr);
            if (v.wr) begin
               chk("wready", wready, 32'(1) << p);
               chk("wdata", mem_din, v.d[k-1]);
            end else begin
               chk("no_wready", wready, 0);
            end
         end else if (k == v.len + 1) begin
            chk("drain_gnt", gnt, 32'(1) << p);
            chk("drain_we", mem_we, 0);
            chk("drain_busy", busy, 1);
         end else begin
            chk("done", done, 32'(1) << p);
            chk("done_gnt", gnt, 0);
            chk("done_busy", busy, 0);
            chk("done_we", mem_we, 0);
            req[p] = 1'b0;
         end
         if (k < v.len + 2) chk("early_done", done, 0);
         if (!v.wr && k >= 2 && k <= v.len + 1) begin
            chk("rvalid", rvalid, 32'(1) << p);
            chk("rdata", rdata, v.d[k-2]);
         end else begin
            chk("no_rvalid", rvalid, 0);
         end
      end
   endtask

   vec_t vt [7];

   initial begin
      int b, ph, ep;
      vt[0] = mk(1, 1'b1, 24'h000010, 4, 32'h44332211);
      vt[1] = mk(0, 1'b0, 24'h000010, 4, 32'h44332211);
      vt[2] = mk(2, 1'b1, 24'h000020, 3, 32'h00CCBBAA);
      vt[3] = mk(1, 1'b0, 24'h000020, 3, 32'h00CCBBAA);
      vt[4] = mk(1, 1'b0, 24'h000030, 0, 32'h00000000);
      vt[5] = mk(0, 1'b1, 24'hFFFFFE, 3, 32'h005C5B5A);
      vt[6] = mk(2, 1'b0, 24'hFFFFFE, 3, 32'h005C5B5A);

      rst_n = 1'b0;
      req = '0; we = '0; addr = '0; len = '0; wdata = '0;
      #3;
      all_quiet("reset");
      @(posedge clk); #2;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // Round-robin with all ports requesting len-1 reads; each port drops its
      // request in its done cycle and re-raises it the following cycle.
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int p = 0; p < NP; p++) begin
         we[p] = 1'b0;
         addr[p*AW +: AW] = 24'h10 + 24'(p);
         len[p*LW +: LW] = 16'd1;
      end
      req = 3'b111;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #2;
         b  = (c - 1) / 3;
         ph = c % 3;
         ep = b % 3;
         if (ph != 0) begin
            chk("rr_gnt", gnt, 32'(1) << ep);
            chk("rr_no_done", done, 0);
         end else begin
            chk("rr_done", done, 32'(1) << ep);
            chk("rr_gap_gnt", gnt, 0);
            req[ep] = 1'b0;
         end
         if (ph == 1 && c > 1) req[(b + 2) % 3] = 1'b1;
         if (ph == 2 && ep == 0) chk("rr_rdata0", rdata, 8'h11);
      end
      req = '0;
      repeat (5) @(posedge clk);
      #2;

      // Reset in the middle of a len-8 read
      we[1] = 1'b0;
      addr[1*AW +: AW] = 24'h10;
      len[1*LW +: LW] = 16'd8;
      req[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_beat", beat, 2);
      rst_n = 1'b0;
      #1;
      all_quiet("midrst");
      req = '0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      // rr pointer back at 0: ports 0 and 2 together must go to port 0 first
      we = '0;
      len[0*LW +: LW] = 16'd1;
      len[2*LW +: LW] = 16'd1;
      req = 3'b101;
      @(posedge clk); #2;
      chk("rr_after_rst", gnt, 3'b001);
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("rr_after_rst_done", done, 3'b001);
      req[0] = 1'b0;
      @(posedge clk); #2;
      chk("rr_after_rst_next", gnt, 3'b100);
      req = '0;
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
